// File: rtl/axi_bram_read_responder.sv
// AXI4 read-channel responder serving INCR/WRAP/FIXED bursts from a 1-cycle-latency BRAM,
// with a 2-entry output buffer so rready back-pressure never loses a beat.
package axi_bram_pkg;
    localparam int AXI_ADDR_WIDTH = 32;
    localparam int AXI_DATA_WIDTH = 32;
    localparam int AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8;

    typedef struct packed {
        logic                      awvalid;
        logic [AXI_ADDR_WIDTH-1:0] awaddr;
        logic [7:0]                awlen;
        logic [2:0]                awsize;
        logic [1:0]                awburst;
        logic                      wvalid;
        logic [AXI_DATA_WIDTH-1:0] wdata;
        logic [AXI_STRB_WIDTH-1:0] wstrb;
        logic                      wlast;
        logic                      bready;
        logic                      arvalid;
        logic [AXI_ADDR_WIDTH-1:0] araddr;
        logic [7:0]                arlen;
        logic [2:0]                arsize;
        logic [1:0]                arburst;
        logic                      rready;
    } axi_req_t;

    typedef struct packed {
        logic                      awready;
        logic                      wready;
        logic                      bvalid;
        logic [1:0]                bresp;
        logic                      arready;
        logic                      rvalid;
        logic [AXI_DATA_WIDTH-1:0] rdata;
        logic [1:0]                rresp;
        logic                      rlast;
    } axi_resp_t;
endpackage

module axi_bram_read_responder
    import axi_bram_pkg::*;
#(
    parameter int                    ADDR_WIDTH = AXI_ADDR_WIDTH,
    parameter int                    DATA_WIDTH = AXI_DATA_WIDTH,
    parameter int                    MEM_DEPTH  = 4096,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h1FC0_0000,
    localparam int                   MEM_AW     = $clog2(MEM_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  axi_req_t              axi_req,
    output axi_resp_t             axi_resp,
    output logic                  mem_en,
    output logic [MEM_AW-1:0]     mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);
    localparam int BYTES      = DATA_WIDTH / 8;
    localparam int BYTE_SHIFT = $clog2(BYTES);
    localparam logic [ADDR_WIDTH:0] ADDR_LIMIT =
        {1'b0, BASE_ADDR} + (ADDR_WIDTH+1)'(MEM_DEPTH * BYTES);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t                  state_reg, state_next;
    logic [MEM_AW-1:0]       word_reg, word_advance;
    logic [7:0]              len_reg;
    logic [1:0]              burst_reg;
    logic                    err_reg;
    logic [8:0]              issue_cnt_reg, sent_cnt_reg;
    logic                    inflight_reg;
    logic [1:0]              count_reg;
    logic                    wr_ptr_reg, rd_ptr_reg;
    logic [1:0][DATA_WIDTH-1:0] fifo_data;

    logic                    ar_fire, ar_err, issue_fire;
    logic                    rvalid, pop, pop_fifo, push, last_beat, wrap_ok;
    logic [DATA_WIDTH-1:0]   in_data, head_data;
    logic [MEM_AW-1:0]       wrap_mask;
    logic                    unused_req;

    assign unused_req = ^axi_req;

    assign ar_fire = (state_reg == IDLE) && axi_req.arvalid;
    assign ar_err  = (axi_req.arsize != 3'(BYTE_SHIFT))
                   || (axi_req.araddr < BASE_ADDR)
                   || ({1'b0, axi_req.araddr} >= ADDR_LIMIT);

    // Error bursts still take issue slots so their beats pace through the buffer like real reads.
    assign issue_fire = (state_reg == ISSUE) && ((count_reg + 2'(inflight_reg)) < 2'd2);

    // The beat returning from BRAM counts as buffered; it is presented directly when the buffer is empty.
    assign in_data   = err_reg ? '0 : mem_rdata;
    assign rvalid    = (count_reg != 2'd0) || inflight_reg;
    assign head_data = (count_reg != 2'd0) ? fifo_data[rd_ptr_reg] : in_data;
    assign pop       = rvalid && axi_req.rready;
    assign pop_fifo  = pop && (count_reg != 2'd0);
    assign push      = inflight_reg && !(pop && (count_reg == 2'd0));
    assign last_beat = (sent_cnt_reg == {1'b0, len_reg});

    assign wrap_ok   = (burst_reg == 2'b10) &&
                       ((len_reg == 8'd1) || (len_reg == 8'd3) || (len_reg == 8'd7) || (len_reg == 8'd15));
    assign wrap_mask = MEM_AW'(len_reg[3:0]);

    always_comb begin
        word_advance = word_reg + MEM_AW'(1);
        if (burst_reg == 2'b00) begin
            word_advance = word_reg;
        end else if (wrap_ok) begin
            word_advance = (word_reg & ~wrap_mask) | ((word_reg + MEM_AW'(1)) & wrap_mask);
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_fifo
        logic [DATA_WIDTH-1:0] entry_reg;
        always_ff @(posedge clk) begin
            if (rst) begin
                entry_reg <= '0;
            end else if (push && (wr_ptr_reg == 1'(gi))) begin
                entry_reg <= in_data;
            end
        end
        assign fifo_data[gi] = entry_reg;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (ar_fire) state_next = ISSUE;
            ISSUE:   if (issue_fire && (issue_cnt_reg == {1'b0, len_reg})) state_next = DRAIN;
            DRAIN:   if (pop && last_beat) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        axi_resp         = '0;
        axi_resp.arready = (state_reg == IDLE);
        axi_resp.rvalid  = rvalid;
        axi_resp.rdata   = rvalid ? head_data : '0;
        axi_resp.rresp   = (rvalid && err_reg) ? 2'b10 : 2'b00;
        axi_resp.rlast   = rvalid && last_beat;
        mem_en           = issue_fire && !err_reg;
        mem_addr         = word_reg;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            word_reg      <= '0;
            len_reg       <= '0;
            burst_reg     <= '0;
            err_reg       <= 1'b0;
            issue_cnt_reg <= '0;
            sent_cnt_reg  <= '0;
            inflight_reg  <= 1'b0;
            count_reg     <= '0;
            wr_ptr_reg    <= 1'b0;
            rd_ptr_reg    <= 1'b0;
        end else begin
            inflight_reg <= issue_fire;
            if (ar_fire) begin
                word_reg      <= axi_req.araddr[BYTE_SHIFT +: MEM_AW];
                len_reg       <= axi_req.arlen;
                burst_reg     <= axi_req.arburst;
                err_reg       <= ar_err;
                issue_cnt_reg <= '0;
                sent_cnt_reg  <= '0;
            end else begin
                if (issue_fire) begin
                    issue_cnt_reg <= issue_cnt_reg + 9'd1;
                    word_reg      <= word_advance;
                end
                if (pop) begin
                    sent_cnt_reg <= sent_cnt_reg + 9'd1;
                end
            end
            if (push) begin
                wr_ptr_reg <= ~wr_ptr_reg;
            end
            if (pop_fifo) begin
                rd_ptr_reg <= ~rd_ptr_reg;
            end
            count_reg <= count_reg + 2'(push) - 2'(pop_fifo);
        end
    end
endmodule

// File: tb/tb_axi_bram_read_responder.sv
// Scoreboard bench: bursts push expected beats from an address-arithmetic model; a monitor pops and compares.
module tb_axi_bram_read_responder;
    import axi_bram_pkg::*;

    localparam logic [31:0] BASE  = 32'h1FC0_0000;
    localparam int          DEPTH = 4096;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    axi_req_t    axi_req;
    axi_resp_t   axi_resp;
    logic        mem_en;
    logic [11:0] mem_addr;
    logic [31:0] mem_rdata = '0;
    logic [31:0] mem [DEPTH];

    logic        ar_valid = 1'b0;
    logic [31:0] ar_addr  = '0;
    logic [7:0]  ar_len   = '0;
    logic [2:0]  ar_size  = '0;
    logic [1:0]  ar_burst = '0;
    logic        rready   = 1'b1;

    beat_t exp_q[$];
    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int hs_cyc = 0;
    int rmode = 0;
    int rphase = 0;
    int beats_seen = 0;
    int mem_en_cnt = 0;
    bit timing_chk = 0;
    bit first_pending = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (mem_en) mem_rdata <= mem[mem_addr];

    always_comb begin
        axi_req         = '0;
        axi_req.arvalid = ar_valid;
        axi_req.araddr  = ar_addr;
        axi_req.arlen   = ar_len;
        axi_req.arsize  = ar_size;
        axi_req.arburst = ar_burst;
        axi_req.rready  = rready;
    end

    axi_bram_read_responder dut (
        .clk       (clk),
        .rst       (rst),
        .axi_req   (axi_req),
        .axi_resp  (axi_resp),
        .mem_en    (mem_en),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Reference: AXI burst address rules on byte addresses, then look up the preloaded memory.
    task automatic push_expected(input logic [31:0] addr, input int len, input logic [1:0] burst,
                                 input logic [2:0] size);
        longint start, total, lower, a;
        bit err;
        beat_t b;
        bit wrap;
        start = longint'(addr);
        err = (size != 3'd2) || (start < longint'(BASE)) || (start >= longint'(BASE) + DEPTH * 4);
        wrap = (burst == 2'b10) && (len == 1 || len == 3 || len == 7 || len == 15);
        total = (len + 1) * 4;
        lower = (start / total) * total;
        for (int i = 0; i <= len; i++) begin
            if (burst == 2'b00) a = start;
            else if (wrap) a = lower + ((start - lower + 4 * i) % total);
            else a = start + 4 * i;
            b.data = err ? 32'h0 : mem[int'((a - longint'(BASE)) / 4)];
            b.resp = err ? 2'b10 : 2'b00;
            b.last = (i == len);
            exp_q.push_back(b);
        end
    endtask

    task automatic do_ar(input logic [31:0] addr, input int len, input logic [1:0] burst,
                         input logic [2:0] size);
        bit got = 0;
        $display("AR addr=0x%08h len=%0d burst=%0d size=%0d", addr, len, burst, size);
        @(posedge clk); #1;
        ar_valid = 1'b1; ar_addr = addr; ar_len = 8'(len); ar_burst = burst; ar_size = size;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (axi_resp.arready) begin
                got = 1;
                hs_cyc = cyc;
                first_pending = 1;
                push_expected(addr, len, burst, size);
                break;
            end
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL ar_handshake: got arready=0 expected 1 within 500 cycles");
        end
        @(posedge clk); #1;
        ar_valid = 1'b0;
    endtask

    task automatic wait_drain();
        bit done = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !axi_resp.rvalid) begin
                done = 1;
                break;
            end
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL drain_timeout: got %0d beats pending expected 0", exp_q.size());
        end
    endtask

    initial forever begin
        @(posedge clk); #1;
        case (rmode)
            0: rready = 1'b1;
            1: begin
                rready = (rphase == 0) || (rphase == 3);
                rphase = (rphase + 1) % 4;
            end
            default: rready = 1'($urandom_range(0, 1));
        endcase
    end

    // Monitor: compares accepted beats, hold stability, and the buffered+inflight bound.
    initial begin
        bit          held = 0;
        logic [31:0] held_data = '0;
        logic        held_last = 0;
        int          issued = 0;
        int          accepted = 0;
        int          last_acc = 0;
        bit          acc_any = 0;
        beat_t       e;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q.delete();
                held = 0; issued = 0; accepted = 0; acc_any = 0; first_pending = 0;
            end else begin
                if (held) begin
                    check("hold_rvalid", 32'(axi_resp.rvalid), 32'd1);
                    check("hold_rdata", axi_resp.rdata, held_data);
                    check("hold_rlast", 32'(axi_resp.rlast), 32'(held_last));
                end
                held = axi_resp.rvalid && !rready;
                held_data = axi_resp.rdata;
                held_last = axi_resp.rlast;
                if (mem_en) begin
                    issued++;
                    mem_en_cnt++;
                    check("outstanding_le_2", 32'(issued - accepted <= 2), 32'd1);
                end
                if (axi_resp.rvalid && first_pending) begin
                    if (timing_chk) check("first_rvalid_latency", 32'(cyc - hs_cyc), 32'd2);
                    first_pending = 0;
                    acc_any = 0;
                end
                if (axi_resp.rvalid && rready) begin
                    beats_seen++;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_beat: got rdata=0x%0h expected no beat", axi_resp.rdata);
                    end else begin
                        e = exp_q.pop_front();
                        check("rdata", axi_resp.rdata, e.data);
                        check("rresp", 32'(axi_resp.rresp), 32'(e.resp));
                        check("rlast", 32'(axi_resp.rlast), 32'(e.last));
                    end
                    if (axi_resp.rresp == 2'b00) accepted++;
                    if (timing_chk && acc_any) check("beat_spacing", 32'(cyc - last_acc), 32'd1);
                    last_acc = cyc;
                    acc_any = 1;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int en_before;
        int bmode;
        logic [31:0] addr;
        for (int i = 0; i < DEPTH; i++) mem[i] = 32'(i * 4) + 32'hA000;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_arready", 32'(axi_resp.arready), 32'd1);
        check("reset_rvalid", 32'(axi_resp.rvalid), 32'd0);
        check("reset_mem_en", 32'(mem_en), 32'd0);
        check("reset_rlast", 32'(axi_resp.rlast), 32'd0);
        check("reset_rresp", 32'(axi_resp.rresp), 32'd0);
        check("reset_rdata", axi_resp.rdata, 32'd0);

        rmode = 0;
        timing_chk = 1;
        do_ar(BASE + 32'h40, 7, 2'b01, 3'd2);
        wait_drain();
        timing_chk = 0;

        rmode = 1; rphase = 0;
        do_ar(BASE + 32'h40, 7, 2'b01, 3'd2);
        wait_drain();
        rmode = 0;

        do_ar(BASE + 32'h18, 3, 2'b10, 3'd2);
        wait_drain();

        en_before = mem_en_cnt;
        do_ar(BASE - 32'd4, 3, 2'b01, 3'd2);
        wait_drain();
        check("err_no_mem_en", 32'(mem_en_cnt - en_before), 32'd0);

        beats_seen = 0;
        do_ar(BASE, 7, 2'b01, 3'd2);
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            if (beats_seen >= 3) break;
        end
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("midreset_arready", 32'(axi_resp.arready), 32'd1);
        check("midreset_rvalid", 32'(axi_resp.rvalid), 32'd0);
        do_ar(BASE, 0, 2'b01, 3'd2);
        wait_drain();

        rmode = 2;
        for (int n = 0; n < 40; n++) begin
            bmode = int'($urandom_range(0, 9));
            if (bmode == 0) addr = BASE - 32'(4 * $urandom_range(1, 8));
            else if (bmode == 1) addr = BASE + 32'(DEPTH * 4) + 32'(4 * $urandom_range(0, 8));
            else addr = BASE + 32'(4 * $urandom_range(0, DEPTH - 17));
            do_ar(addr, int'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
                  ($urandom_range(0, 9) == 0) ? 3'd1 : 3'd2);
        end
        wait_drain();
        rmode = 0;
        repeat (4) @(negedge clk);
        check("queue_empty_at_end", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/axi_bram_read_responder.md
Name: axi_bram_read_responder

Overview:
- AXI4 read-channel responder (slave) that serves INCR/WRAP/FIXED read bursts from a synchronous single-read-port BRAM with 1-cycle read latency.
- Sits on the memory side of the instruction-bus path and answers cache-line refill bursts (e.g. 8 x 32-bit INCR) from the instruction cache controller.
- Supports full rready back-pressure without data loss, using a 2-entry output buffer.
- Sustains 1 beat/cycle when rready is held high.

Parameters:
- ADDR_WIDTH, 32, AXI address width.
- DATA_WIDTH, 32, beat width in bits; only arsize = log2(DATA_WIDTH/8) is legal.
- MEM_DEPTH, 4096, BRAM words; word index = araddr[log2(DATA_WIDTH/8) +: log2(MEM_DEPTH)].
- BASE_ADDR, 32'h1FC0_0000, first byte address decoded by this block.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- axi_req  in  axi_req_t  master request; fields used: arvalid, araddr, arlen, arsize, arburst, rready (write-channel fields ignored)
- axi_resp  out  axi_resp_t  response; fields driven: arready, rvalid, rdata, rresp, rlast; all other fields 0
- mem_en  out  1  BRAM read enable
- mem_addr  out  log2(MEM_DEPTH)  BRAM word address
- mem_rdata  in  DATA_WIDTH  BRAM data, valid the cycle after mem_en

Behaviour:
- Reset (rst=1 at a clock edge):
  - state=IDLE; output buffer and inflight flag cleared; beat counters 0.
  - Outputs after reset: arready=1, rvalid=0, rlast=0, rresp=0, rdata=0, mem_en=0.
  - rst mid-burst discards the remaining beats; no rlast is produced.
- States: IDLE, ISSUE, DRAIN.
- IDLE:
  - arready=1.
  - arvalid & arready -> latch addr, len, burst, size; issue_cnt=0; sent_cnt=0; go to ISSUE.
  - Decode error if the address lies outside [BASE_ADDR, BASE_ADDR + MEM_DEPTH*DATA_WIDTH/8) or arsize is illegal.
- ISSUE:
  - arready=0.
  - Each cycle where (buffer occupancy + inflight) < 2, assert mem_en and drive mem_addr = current word address, then increment issue_cnt and advance the address.
  - When issue_cnt reaches len+1 -> DRAIN.
- DRAIN:
  - No new mem_en.
  - When the beat with sent_cnt==len is accepted (rvalid & rready) -> IDLE.
  - arready returns to 1 in the cycle after the last handshake.
- Address advance:
  - FIXED (00): address unchanged.
  - INCR (01): +DATA_WIDTH/8.
  - WRAP (10): increment within a boundary aligned to (len+1)*DATA_WIDTH/8. len must be 1, 3, 7 or 15; any other len is treated as INCR.
  - Reserved (11): treated as INCR.
- Data capture: on the cycle after mem_en, mem_rdata is pushed into the 2-entry FIFO.
- Output:
  - rvalid = FIFO non-empty; rdata = FIFO head.
  - rlast=1 only on the head beat whose index == len.
  - Pop on rvalid & rready.
  - rvalid, rdata and rlast hold stable while rready=0.
- Error bursts:
  - No mem_en is issued.
  - Beats still pace through the FIFO, each with rdata=0 and rresp=2'b10 (SLVERR).
  - All len+1 beats are returned; rlast is on the final beat.
- Latency: AR handshake at edge T -> first mem_en in cycle T+1 -> first rvalid in cycle T+2. Throughput is 1 beat/cycle when rready stays high.
- Back-pressure: rready low with the FIFO full (2 entries) stops mem_en issue. Resumption is lossless and in order.
- Single outstanding burst: a new AR is accepted only in IDLE. arvalid during ISSUE/DRAIN waits without being dropped.
- Single-beat burst (len=0): mem_en in one cycle only; rvalid with rlast=1 next cycle; then back to IDLE.
- Simultaneous push and pop with FIFO full: allowed; occupancy stays 2.

Test Plan:
- Reset then idle -> arready=1, rvalid=0, mem_en=0. BRAM preloaded mem[i]=i*4+32'hA000 for all following tests.
- INCR refill, araddr=BASE+0x40, arlen=7, rready=1 -> rvalid first asserted 2 cycles after AR handshake; rdata sequence 0xA040..0xA05C on 8 consecutive cycles; rlast only on beat 7; rresp=0.
- Same burst with rready toggling 1,0,0,1 repeatedly -> no beat lost or duplicated; rdata stable while rready=0; mem_en never causes more than 2 buffered+inflight beats.
- WRAP, araddr=BASE+0x18, arlen=3 -> rdata 0xA018, 0xA01C, 0xA010, 0xA014; rlast on 0xA014.
- Out-of-range araddr=BASE-4, arlen=3 -> 4 beats with rdata=0 and rresp=2'b10; rlast on beat 3; mem_en never asserted.
- rst asserted after beat 2 of an arlen=7 burst, then a new len=0 burst at BASE -> remaining beats discarded; new burst returns a single beat 0xA000 with rlast=1.
